// File: rtl/mem_arbiter_pkg.sv
// lib_cpu: shared widths and arbiter state encoding for the program-memory
// arbiter that lets a loader take the CPU's instruction memory for a while.
// Contents:
//   ADDR_W, DATA_W - program memory address / data widths
//   ARB_STATE      - arbiter FSM state encoding
package lib_cpu;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    HANDOVER = 2'd1,
    LD_OWN   = 2'd2,
    RETURN   = 2'd3
  } ARB_STATE;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the CPU fetch port, loader port and program memory
// port of the arbiter.
//   cpu_addr/cpu_data/cpu_en                  CPU fetch side
//   ld_req/ld_valid/ld_we/ld_addr/ld_wdata    loader request side
//   ld_gnt/ld_ack/ld_rdata                    loader response side
//   mem_addr/mem_we/mem_wdata/mem_rdata       program memory side
// Modports:
//   slave  - the arbiter
//   master - the environment (CPU, loader and memory)
interface mem_arbiter_if;
  import lib_cpu::*;

  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_en;

  logic              ld_req;
  logic              ld_valid;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_addr, ld_req, ld_valid, ld_we, ld_addr, ld_wdata, mem_rdata,
    output cpu_data, cpu_en, ld_gnt, ld_ack, ld_rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_addr, ld_req, ld_valid, ld_we, ld_addr, ld_wdata, mem_rdata,
    input  cpu_data, cpu_en, ld_gnt, ld_ack, ld_rdata, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter_fsm.sv
// arb_fsm: ownership sequencer for the program memory. Holds the state, the
// loader burst counter and the CPU cooldown counter.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_ld_req   loader ownership request (level)
//   o_state    current owner state
//
// state    | meaning
// ---------+--------------------------------------------------------
// CPU_OWN  | CPU fetches; loader request honoured once cooldown is 0
// HANDOVER | one idle turnaround cycle before the loader gets memory
// LD_OWN   | loader owns memory, at most BURST_MAX cycles
// RETURN   | one idle turnaround cycle before the CPU gets memory back
module arb_fsm
  import lib_cpu::*;
#(
  parameter int BURST_MAX = 8,
  parameter int CPU_MIN   = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     i_ld_req,
  output ARB_STATE o_state
);

  localparam int BW = (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
  localparam int CW = (CPU_MIN > 0) ? $clog2(CPU_MIN + 1) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'((BURST_MAX > 0) ? BURST_MAX - 1 : 0);
  // The cooldown counts CPU_OWN cycles still owed after the current one, so
  // the first CPU_OWN cycle after RETURN already counts towards CPU_MIN.
  localparam logic [CW-1:0] COOL_LOAD  = CW'((CPU_MIN > 0) ? CPU_MIN - 1 : 0);

  ARB_STATE      r_state, w_state_nxt;
  logic [BW-1:0] r_burst, w_burst_nxt;
  logic [CW-1:0] r_cool,  w_cool_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CPU_OWN;
      r_burst <= '0;
      r_cool  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
      r_cool  <= w_cool_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_cool_nxt  = r_cool;
    case (r_state)
      CPU_OWN: begin
        if (r_cool != '0) w_cool_nxt = r_cool - CW'(1);
        else if (i_ld_req) w_state_nxt = HANDOVER;
      end
      HANDOVER: begin
        w_state_nxt = LD_OWN;
        w_burst_nxt = '0;
      end
      LD_OWN: begin
        w_burst_nxt = r_burst + BW'(1);
        if (!i_ld_req || r_burst == BURST_LAST) w_state_nxt = RETURN;
      end
      RETURN: begin
        w_state_nxt = CPU_OWN;
        w_cool_nxt  = COOL_LOAD;
      end
      default: w_state_nxt = CPU_OWN;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one combinational-read program memory between the CPU
// fetch path and a bursting loader. Ownership sequencing lives in arb_fsm;
// this module muxes the memory port and registers the loader ack/read data.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        mem_arbiter_if.slave (CPU, loader and memory signals)
module mem_arbiter
  import lib_cpu::*;
#(
  parameter int BURST_MAX = 8,
  parameter int CPU_MIN   = 4
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);

  ARB_STATE          w_state;
  logic              w_accept;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_cpu_data;
  logic              w_cpu_en;
  logic              w_ld_gnt;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;

  arb_fsm #(
    .BURST_MAX(BURST_MAX),
    .CPU_MIN  (CPU_MIN)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .i_ld_req(bus.ld_req),
    .o_state (w_state)
  );

  // A dropping ld_req in LD_OWN cancels that cycle's access as well.
  assign w_accept = (w_state == LD_OWN) && bus.ld_req && bus.ld_valid;

  always_comb begin
    w_mem_addr = bus.cpu_addr;
    w_mem_we   = 1'b0;
    w_cpu_data = '0;
    w_cpu_en   = 1'b0;
    w_ld_gnt   = 1'b0;
    case (w_state)
      CPU_OWN: begin
        w_cpu_data = bus.mem_rdata;
        w_cpu_en   = 1'b1;
      end
      LD_OWN: begin
        w_mem_addr = bus.ld_addr;
        w_mem_we   = w_accept && bus.ld_we;
        w_ld_gnt   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_accept;
      if (w_accept && !bus.ld_we) r_rdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wdata = bus.ld_wdata;
  assign bus.cpu_data  = w_cpu_data;
  assign bus.cpu_en    = w_cpu_en;
  assign bus.ld_gnt    = w_ld_gnt;
  assign bus.ld_ack    = r_ack;
  assign bus.ld_rdata  = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  logic [7:0] mem [16];

  mem_arbiter_if bus ();

  mem_arbiter #(.BURST_MAX(8), .CPU_MIN(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
      mem[3] <= 8'hB1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.cpu_addr = 4'h3;
    bus.ld_req = 1'b0; bus.ld_valid = 1'b0; bus.ld_we = 1'b0;
    bus.ld_addr = 4'h0; bus.ld_wdata = 8'h00;
    step();
    step();
    rst = 1'b0;
    sample();
    n_chk++; if (bus.cpu_en !== 1'b1) $display("FAIL rst_cpu_en got=%0h exp=1", bus.cpu_en); else n_pass++;
    n_chk++; if (bus.ld_gnt !== 1'b0) $display("FAIL rst_ld_gnt got=%0h exp=0", bus.ld_gnt); else n_pass++;
    n_chk++; if (bus.ld_ack !== 1'b0) $display("FAIL rst_ld_ack got=%0h exp=0", bus.ld_ack); else n_pass++;
    n_chk++; if (bus.ld_rdata !== 8'h00) $display("FAIL rst_ld_rdata got=%0h exp=00", bus.ld_rdata); else n_pass++;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      step();
      sample();
      n_chk++; if (bus.cpu_data !== 8'hB1) $display("FAIL idle_cpu_data cyc=%0d got=%0h exp=b1", i, bus.cpu_data); else n_pass++;
      n_chk++; if (bus.cpu_en !== 1'b1) $display("FAIL idle_cpu_en cyc=%0d got=%0h exp=1", i, bus.cpu_en); else n_pass++;
      n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL idle_mem_we cyc=%0d got=%0h exp=0", i, bus.mem_we); else n_pass++;
    end
  endtask

  task automatic test_grant_timing();
    step();
    bus.ld_req = 1'b1;
    sample();
    n_chk++; if (bus.cpu_en !== 1'b1) $display("FAIL gnt_t_cpu_en got=%0h exp=1", bus.cpu_en); else n_pass++;
    n_chk++; if (bus.ld_gnt !== 1'b0) $display("FAIL gnt_t_ld_gnt got=%0h exp=0", bus.ld_gnt); else n_pass++;
    // HANDOVER: a loader strobe here must be ignored
    step();
    bus.ld_valid = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 4'h5; bus.ld_wdata = 8'h77;
    sample();
    n_chk++; if (bus.cpu_en !== 1'b0) $display("FAIL gnt_t1_cpu_en got=%0h exp=0", bus.cpu_en); else n_pass++;
    n_chk++; if (bus.ld_gnt !== 1'b0) $display("FAIL gnt_t1_ld_gnt got=%0h exp=0", bus.ld_gnt); else n_pass++;
    n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL gnt_t1_mem_we got=%0h exp=0", bus.mem_we); else n_pass++;
    n_chk++; if (bus.cpu_data !== 8'h00) $display("FAIL gnt_t1_cpu_data got=%0h exp=00", bus.cpu_data); else n_pass++;
  endtask

  task automatic test_write_read();
    step();
    bus.ld_valid = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 4'hA; bus.ld_wdata = 8'h5A;
    sample();
    n_chk++; if (bus.ld_gnt !== 1'b1) $display("FAIL gnt_t2_ld_gnt got=%0h exp=1", bus.ld_gnt); else n_pass++;
    n_chk++; if (bus.ld_ack !== 1'b0) $display("FAIL wr_k_no_ack got=%0h exp=0", bus.ld_ack); else n_pass++;
    n_chk++; if (bus.mem_we !== 1'b1) $display("FAIL wr_k_mem_we got=%0h exp=1", bus.mem_we); else n_pass++;
    n_chk++; if (bus.mem_addr !== 4'hA) $display("FAIL wr_k_mem_addr got=%0h exp=a", bus.mem_addr); else n_pass++;
    n_chk++; if (bus.mem_wdata !== 8'h5A) $display("FAIL wr_k_mem_wdata got=%0h exp=5a", bus.mem_wdata); else n_pass++;
    step();
    bus.ld_valid = 1'b0; bus.ld_we = 1'b0;
    sample();
    n_chk++; if (bus.ld_ack !== 1'b1) $display("FAIL wr_k1_ack got=%0h exp=1", bus.ld_ack); else n_pass++;
    n_chk++; if (bus.ld_rdata !== 8'h00) $display("FAIL wr_k1_rdata_hold got=%0h exp=00", bus.ld_rdata); else n_pass++;
    n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL wr_k1_mem_we got=%0h exp=0", bus.mem_we); else n_pass++;
    step();
    bus.ld_valid = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 4'hA;
    sample();
    n_chk++; if (bus.ld_ack !== 1'b0) $display("FAIL rd_k2_ack got=%0h exp=0", bus.ld_ack); else n_pass++;
    n_chk++; if (bus.mem_addr !== 4'hA) $display("FAIL rd_k2_mem_addr got=%0h exp=a", bus.mem_addr); else n_pass++;
    step();
    bus.ld_valid = 1'b0;
    sample();
    n_chk++; if (bus.ld_ack !== 1'b1) $display("FAIL rd_k3_ack got=%0h exp=1", bus.ld_ack); else n_pass++;
    n_chk++; if (bus.ld_rdata !== 8'h5A) $display("FAIL rd_k3_rdata got=%0h exp=5a", bus.ld_rdata); else n_pass++;
  endtask

  task automatic test_release();
    step();
    bus.ld_req = 1'b0; bus.ld_valid = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 4'hA; bus.ld_wdata = 8'hFF;
    sample();
    n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL rel_mem_we got=%0h exp=0", bus.mem_we); else n_pass++;
    n_chk++; if (bus.ld_gnt !== 1'b1) $display("FAIL rel_ld_gnt got=%0h exp=1", bus.ld_gnt); else n_pass++;
    step();
    bus.ld_valid = 1'b0; bus.ld_we = 1'b0;
    sample();
    n_chk++; if (bus.ld_gnt !== 1'b0) $display("FAIL rel_ret_ld_gnt got=%0h exp=0", bus.ld_gnt); else n_pass++;
    n_chk++; if (bus.cpu_en !== 1'b0) $display("FAIL rel_ret_cpu_en got=%0h exp=0", bus.cpu_en); else n_pass++;
    n_chk++; if (bus.ld_ack !== 1'b0) $display("FAIL rel_ret_no_ack got=%0h exp=0", bus.ld_ack); else n_pass++;
    n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL rel_ret_mem_we got=%0h exp=0", bus.mem_we); else n_pass++;
    step();
    bus.cpu_addr = 4'hA;
    sample();
    n_chk++; if (bus.cpu_en !== 1'b1) $display("FAIL rel_cpu_en got=%0h exp=1", bus.cpu_en); else n_pass++;
    n_chk++; if (bus.cpu_data !== 8'h5A) $display("FAIL rel_cpu_data got=%0h exp=5a", bus.cpu_data); else n_pass++;
  endtask

  // c0 request, c1 HANDOVER, c2-c9 LD_OWN, c10 RETURN, c11-c14 CPU_OWN,
  // c15 HANDOVER, c16 LD_OWN again
  task automatic test_burst_limit();
    logic exp_en  [17] = '{1,0,0,0,0,0,0,0,0,0,0,1,1,1,1,0,0};
    logic exp_gnt [17] = '{0,0,1,1,1,1,1,1,1,1,0,0,0,0,0,0,1};
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 0) bus.ld_req = 1'b1;
      sample();
      n_chk++; if (bus.cpu_en !== exp_en[i]) $display("FAIL burst_cpu_en cyc=%0d got=%0h exp=%0h", i, bus.cpu_en, exp_en[i]); else n_pass++;
      n_chk++; if (bus.ld_gnt !== exp_gnt[i]) $display("FAIL burst_ld_gnt cyc=%0d got=%0h exp=%0h", i, bus.ld_gnt, exp_gnt[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_burst();
    step();
    sample();
    n_chk++; if (bus.ld_gnt !== 1'b1) $display("FAIL mid_c2_ld_gnt got=%0h exp=1", bus.ld_gnt); else n_pass++;
    step();
    bus.ld_valid = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 4'h3; rst = 1'b1;
    sample();
    n_chk++; if (bus.ld_gnt !== 1'b1) $display("FAIL mid_c3_ld_gnt got=%0h exp=1", bus.ld_gnt); else n_pass++;
    step();
    rst = 1'b0; bus.ld_req = 1'b0; bus.ld_valid = 1'b0;
    sample();
    n_chk++; if (bus.ld_ack !== 1'b0) $display("FAIL mid_no_ack got=%0h exp=0", bus.ld_ack); else n_pass++;
    n_chk++; if (bus.ld_gnt !== 1'b0) $display("FAIL mid_ld_gnt got=%0h exp=0", bus.ld_gnt); else n_pass++;
    n_chk++; if (bus.cpu_en !== 1'b1) $display("FAIL mid_cpu_en got=%0h exp=1", bus.cpu_en); else n_pass++;
    n_chk++; if (bus.ld_rdata !== 8'h00) $display("FAIL mid_rdata_clr got=%0h exp=00", bus.ld_rdata); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_idle();
    test_grant_timing();
    test_write_read();
    test_release();
    test_burst_limit();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
